br_credit_sender_vc: RTL and testbench

- Multi-virtual-channel credit sender: NumVcs ready/valid push flows share one credit/valid link.
- Each VC has a dedicated credit pool; all VCs also draw on a shared pool.
- Round-robin arbitration picks at most one flit per cycle.
- Sits where a single-pool credit sender is used today, on links whose receiver has per-VC reserved buffering plus a shared buffer.

---
 rtl/br_credit_vc_pkg.sv | 14 +
 rtl/br_credit_vc_counter.sv | 70 +++++++
 rtl/br_credit_sender_vc.sv | 204 ++++++++++++++++++++
 tb/tb_br_credit_sender_vc.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_credit_vc_pkg.sv
// Shared types and constants for the multi-VC credit sender.
package br_credit_vc_pkg;

  localparam int StallCountWidth  = 16;
  localparam int CreditFieldWidth = 16;

  // Per-VC credit bookkeeping: credits left in the VC's own pool and
  // credits currently borrowed from the shared pool.
  typedef struct packed {
    logic [CreditFieldWidth-1:0] ded;
    logic [CreditFieldWidth-1:0] borrowed;
  } vc_credit_t;

endpackage

// File: rtl/br_credit_vc_counter.sv
// Per-VC dedicated/borrowed credit bookkeeping.
// A consume draws from the dedicated pool first and borrows from the shared
// pool only when the dedicated pool is empty. Returned credits repay borrowed
// credits first; the remainder refills the dedicated pool, saturating on
// over-return.
module br_credit_vc_counter
  import br_credit_vc_pkg::*;
#(
  parameter int DedicatedCredit = 2,
  parameter int RetWidth        = 1,
  parameter int ShWidth         = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        consume,
  input  logic [RetWidth-1:0]         ret,
  output logic [CreditFieldWidth-1:0] ded,
  output logic                        draw_shared,
  output logic [ShWidth-1:0]          give_shared,
  output logic                        over_return
);

  vc_credit_t state_q;
  vc_credit_t state_d;
  int         ded_mid;
  int         bor_mid;
  int         ret_i;
  int         to_shared;
  int         ded_sum;

  // Apply this cycle's consume, then the return on top of the post-consume state.
  always_comb begin
    ded_mid     = int'(state_q.ded);
    bor_mid     = int'(state_q.borrowed);
    ret_i       = int'(ret);
    draw_shared = 1'b0;
    if (consume) begin
      if (state_q.ded != '0) begin
        ded_mid = ded_mid - 1;
      end else begin
        bor_mid     = bor_mid + 1;
        draw_shared = 1'b1;
      end
    end
    to_shared        = (ret_i < bor_mid) ? ret_i : bor_mid;
    ded_sum          = ded_mid + ret_i - to_shared;
    over_return      = (ded_sum > DedicatedCredit);
    state_d.ded      = over_return ? CreditFieldWidth'(DedicatedCredit)
                                   : CreditFieldWidth'(ded_sum);
    state_d.borrowed = CreditFieldWidth'(bor_mid - to_shared);
    give_shared      = ShWidth'(to_shared);
  end

  // Credit state register; the far-end reset restores the reset pool.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q.ded      <= CreditFieldWidth'(DedicatedCredit);
      state_q.borrowed <= '0;
    end else if (clear) begin
      state_q.ded      <= CreditFieldWidth'(DedicatedCredit);
      state_q.borrowed <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign ded = state_q.ded;

endmodule

// File: rtl/br_credit_sender_vc.sv
// Multi-virtual-channel credit sender: NumVcs push flows share one
// credit/valid link. Each VC owns a dedicated credit pool and may borrow
// from a shared pool; a round-robin arbiter sends at most one flit per cycle.
// Optional per-VC stall counters: define BR_CREDIT_SENDER_VC_STALL_STATS_EN.
module br_credit_sender_vc
  import br_credit_vc_pkg::*;
#(
  parameter int NumVcs             = 2,
  parameter int Width              = 8,
  parameter int DedicatedCredit    = 2,
  parameter int SharedCredit       = 4,
  parameter int PopCreditMaxChange = 1,
  parameter int RegisterPopOutputs = 1,
  localparam int VcWidth  = ($clog2(NumVcs) < 1) ? 1 : $clog2(NumVcs),
  localparam int DedWidth = $clog2(DedicatedCredit + 1),
  // Kept at least one bit so an empty shared pool still has a legal vector.
  localparam int ShWidth  = ($clog2(SharedCredit + 1) < 1) ? 1 : $clog2(SharedCredit + 1),
  localparam int RetWidth = $clog2(PopCreditMaxChange + 1),
  localparam int AvWidth  = DedWidth + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumVcs-1:0]             push_valid,
  output logic [NumVcs-1:0]             push_ready,
  input  logic [NumVcs*Width-1:0]       push_data,
  input  logic                          pop_receiver_in_reset,
  output logic                          pop_sender_in_reset,
  input  logic [NumVcs*RetWidth-1:0]    pop_credit,
  output logic                          pop_valid,
  output logic [VcWidth-1:0]            pop_vc,
  output logic [Width-1:0]              pop_data,
  output logic [NumVcs*AvWidth-1:0]     credit_available,
  output logic                          credit_error,
  output logic [NumVcs*StallCountWidth-1:0] stall_count
);

  localparam int AvailMax = (1 << AvWidth) - 1;

  // The sum of dedicated and shared credits is clamped to the field width
  // for configurations where the shared pool outgrows it.
  function automatic logic [AvWidth-1:0] sat_available(input int sum);
    if (sum > AvailMax) return AvWidth'(AvailMax);
    return AvWidth'(sum);
  endfunction

  logic                                     clear;
  logic [ShWidth-1:0]                       shared_q;
  logic [ShWidth-1:0]                       shared_d;
  int                                       shared_sum;
  logic [VcWidth-1:0]                       rr_q;
  logic [VcWidth-1:0]                       rr_d;
  logic [VcWidth-1:0]                       winner;
  logic                                     any_grant;
  int                                       idx;
  logic [NumVcs-1:0]                        elig;
  logic [NumVcs-1:0]                        grant;
  logic [NumVcs-1:0]                        draw_shared;
  logic [NumVcs-1:0]                        over_return;
  logic [NumVcs-1:0][ShWidth-1:0]           give_shared;
  logic [NumVcs-1:0][CreditFieldWidth-1:0]  ded;
  logic [Width-1:0]                         win_data;
  logic                                     credit_error_q;
  logic                                     sender_rst_q;

  assign clear = pop_receiver_in_reset;

  for (genvar v = 0; v < NumVcs; v++) begin : g_vc
    br_credit_vc_counter #(
      .DedicatedCredit(DedicatedCredit),
      .RetWidth       (RetWidth),
      .ShWidth        (ShWidth)
    ) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .consume    (grant[v]),
      .ret        (pop_credit[v*RetWidth +: RetWidth]),
      .ded        (ded[v]),
      .draw_shared(draw_shared[v]),
      .give_shared(give_shared[v]),
      .over_return(over_return[v])
    );

    assign elig[v] = push_valid[v] && ((ded[v] != '0) || (shared_q != '0)) && !clear;
    assign credit_available[v*AvWidth +: AvWidth] =
      sat_available(int'(ded[v]) + int'(shared_q));
  end

  // Round-robin pick starting at the pointer; pointer moves past the winner.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int i = 0; i < NumVcs; i++) begin
      idx = (int'(rr_q) + i) % NumVcs;
      if (!any_grant && elig[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        winner     = VcWidth'(idx);
      end
    end
    rr_d = rr_q;
    if (any_grant) begin
      rr_d = (int'(winner) == NumVcs - 1) ? '0 : winner + VcWidth'(1);
    end
  end

  assign push_ready = grant;
  assign win_data   = push_data[int'(winner)*Width +: Width];

  // Shared pool: one borrow at most per cycle, plus every VC's repayment.
  always_comb begin
    shared_sum = int'(shared_q);
    for (int v = 0; v < NumVcs; v++) begin
      shared_sum = shared_sum - int'(draw_shared[v]) + int'(give_shared[v]);
    end
    shared_d = ShWidth'(shared_sum);
  end

  // Shared pool, arbitration pointer and sticky over-return flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shared_q       <= ShWidth'(SharedCredit);
      rr_q           <= '0;
      credit_error_q <= 1'b0;
    end else if (clear) begin
      shared_q       <= ShWidth'(SharedCredit);
      rr_q           <= '0;
      credit_error_q <= 1'b0;
    end else begin
      shared_q <= shared_d;
      rr_q     <= rr_d;
      if (|over_return) credit_error_q <= 1'b1;
    end
  end

  assign credit_error = credit_error_q;

  // Sender-in-reset indication, set asynchronously and held one cycle past reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sender_rst_q <= 1'b1;
    else        sender_rst_q <= 1'b0;
  end

  assign pop_sender_in_reset = sender_rst_q;

  if (RegisterPopOutputs != 0) begin : g_pop_reg
    logic               vld_p1;
    logic [VcWidth-1:0] vc_p1;
    logic [Width-1:0]   data_p1;

    // Stage p0 -> p1: retime the granted flit onto the link; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1  <= 1'b0;
        vc_p1   <= '0;
        data_p1 <= '0;
      end else if (clear) begin
        vld_p1  <= 1'b0;
        vc_p1   <= '0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= any_grant;
        if (any_grant) begin
          vc_p1   <= winner;
          data_p1 <= win_data;
        end
      end
    end

    assign pop_valid = vld_p1;
    assign pop_vc    = vc_p1;
    assign pop_data  = data_p1;
  end else begin : g_pop_comb
    assign pop_valid = any_grant;
    assign pop_vc    = winner;
    assign pop_data  = any_grant ? win_data : '0;
  end

`ifdef BR_CREDIT_SENDER_VC_STALL_STATS_EN
  logic [NumVcs-1:0][StallCountWidth-1:0] stall_q;

  // Count cycles a VC offers a flit but is not granted, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (clear) begin
      stall_q <= '0;
    end else begin
      for (int v = 0; v < NumVcs; v++) begin
        if (push_valid[v] && !grant[v] && (stall_q[v] != '1)) begin
          stall_q[v] <= stall_q[v] + StallCountWidth'(1);
        end
      end
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_br_credit_sender_vc.sv
// Self-checking bench for br_credit_sender_vc (2 VCs, 2 dedicated, 2 shared,
// registered pop outputs) with directed scenarios and a randomized phase.
module tb_br_credit_sender_vc;

  localparam int NV   = 2;
  localparam int W    = 8;
  localparam int DC   = 2;
  localparam int SC   = 2;
  localparam int PCMC = 2;
  localparam int VCW  = 1;
  localparam int RETW = 2;
  localparam int AVW  = 3;
  localparam int AVMAX = 7;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NV-1:0]       push_valid;
  logic [NV-1:0]       push_ready;
  logic [NV*W-1:0]     push_data;
  logic                pop_receiver_in_reset;
  logic                pop_sender_in_reset;
  logic [NV*RETW-1:0]  pop_credit;
  logic                pop_valid;
  logic [VCW-1:0]      pop_vc;
  logic [W-1:0]        pop_data;
  logic [NV*AVW-1:0]   credit_available;
  logic                credit_error;
  logic [NV*16-1:0]    stall_count;

  always #5 clk = ~clk;

  br_credit_sender_vc #(
    .NumVcs            (NV),
    .Width             (W),
    .DedicatedCredit   (DC),
    .SharedCredit      (SC),
    .PopCreditMaxChange(PCMC),
    .RegisterPopOutputs(1)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .push_valid           (push_valid),
    .push_ready           (push_ready),
    .push_data            (push_data),
    .pop_receiver_in_reset(pop_receiver_in_reset),
    .pop_sender_in_reset  (pop_sender_in_reset),
    .pop_credit           (pop_credit),
    .pop_valid            (pop_valid),
    .pop_vc               (pop_vc),
    .pop_data             (pop_data),
    .credit_available     (credit_available),
    .credit_error         (credit_error),
    .stall_count          (stall_count)
  );

  // Reference model: pools, loans, flits in flight, and the expected link word.
  int         m_ded[NV];
  int         m_bor[NV];
  int         m_out[NV];
  int         m_stall[NV];
  int         m_sh;
  int         m_rr;
  int         m_err;
  int         m_pv;
  int         m_pop_vc;
  int         m_pop_data;
  logic [W-1:0] cur_data[NV];

  int         n_cmp;
  int         n_bad;

  int         obs_ready;
  int         obs_ca[NV];
  int         obs_err;
  int         obs_pv;
  int         obs_vc;
  int         last_win;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ded[v]   = DC;
      m_bor[v]   = 0;
      m_out[v]   = 0;
      m_stall[v] = 0;
    end
    m_sh       = SC;
    m_rr       = 0;
    m_err      = 0;
    m_pv       = 0;
    m_pop_vc   = 0;
    m_pop_data = 0;
  endtask

  // One clock: drive inputs, check every output against the model, advance the model.
  task automatic step(input logic [NV-1:0] pv, input int rc0, input int rc1, input logic rir);
    int rc[NV];
    int win;
    int r;
    int s;
    int exp_ca;
    logic [NV-1:0] exp_ready;
    rc[0] = rc0;
    rc[1] = rc1;
    @(negedge clk);
    push_valid = pv;
    for (int v = 0; v < NV; v++) begin
      push_data[v*W +: W]          = cur_data[v];
      pop_credit[v*RETW +: RETW]   = RETW'(rc[v]);
    end
    pop_receiver_in_reset = rir;
    #1;
    // first requesting VC with any usable credit, searching from the pointer
    win = -1;
    if (!rir) begin
      for (int i = 0; i < NV; i++) begin
        int vv;
        vv = (m_rr + i) % NV;
        if (win < 0 && pv[vv] && (m_ded[vv] + m_sh) > 0) win = vv;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("push_ready", push_ready, exp_ready);
    for (int v = 0; v < NV; v++) begin
      exp_ca = m_ded[v] + m_sh;
      if (exp_ca > AVMAX) exp_ca = AVMAX;
      chk("credit_available", credit_available[v*AVW +: AVW], exp_ca);
      chk("stall_count", stall_count[v*16 +: 16], m_stall[v]);
      obs_ca[v] = int'(credit_available[v*AVW +: AVW]);
    end
    chk("credit_error", credit_error, m_err);
    chk("pop_valid", pop_valid, m_pv);
    if (m_pv != 0) chk("pop_vc", pop_vc, m_pop_vc);
    chk("pop_data", pop_data, m_pop_data);
    chk("pop_sender_in_reset", pop_sender_in_reset, 0);
    obs_ready = int'(push_ready);
    obs_err   = int'(credit_error);
    obs_pv    = int'(pop_valid);
    obs_vc    = int'(pop_vc);

    if (rir) begin
      model_reset();
    end else begin
      if (win >= 0) begin
        if (m_ded[win] > 0) m_ded[win]--;
        else begin
          m_sh--;
          m_bor[win]++;
        end
        m_out[win]++;
        m_rr       = (win + 1) % NV;
        m_pv       = 1;
        m_pop_vc   = win;
        m_pop_data = int'(cur_data[win]);
      end else begin
        m_pv = 0;
      end
      for (int v = 0; v < NV; v++) begin
        r = rc[v];
        s = (r < m_bor[v]) ? r : m_bor[v];
        m_bor[v] -= s;
        m_sh     += s;
        m_ded[v] += r - s;
        if (m_ded[v] > DC) begin
          m_ded[v] = DC;
          m_err    = 1;
        end
        m_out[v] -= (r < m_out[v]) ? r : m_out[v];
`ifdef BR_CREDIT_SENDER_VC_STALL_STATS_EN
        if (pv[v] && win != v && m_stall[v] < 65535) m_stall[v]++;
`endif
      end
    end
    if (win >= 0) cur_data[win] = W'($urandom);
    last_win = win;
  endtask

  initial begin
    logic [NV-1:0] pv;
    logic [NV-1:0] pend;
    int rc[NV];
    int mx;
    int accepted;
    logic rir;

    n_cmp = 0;
    n_bad = 0;
    push_valid = '0;
    push_data  = '0;
    pop_credit = '0;
    pop_receiver_in_reset = 1'b0;
    rst_n = 1'b0;
    last_win = -1;
    model_reset();
    for (int v = 0; v < NV; v++) cur_data[v] = W'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_push_ready", push_ready, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_vc", pop_vc, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_credit_error", credit_error, 0);
    chk("rst_sender_in_reset", pop_sender_in_reset, 1);
    chk("rst_ca0", credit_available[0 +: AVW], 4);
    chk("rst_ca1", credit_available[AVW +: AVW], 4);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sender_in_reset_held", pop_sender_in_reset, 1);

    // VC0 alone: 2 dedicated + 2 borrowed flits, then stall
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 0, 0, 1'b0);
      accepted += obs_ready & 1;
    end
    chk("t1_accepted", accepted, 4);
    step(2'b01, 0, 0, 1'b0);
    chk("t1_fifth_stalls", obs_ready, 0);
    chk("t1_ca1", obs_ca[1], 2);
    chk("t1_last_pop_vc", obs_vc, 0);
    chk("t1_model_borrowed0", m_bor[0], 2);

    // Returns on VC0 repay the shared pool before refilling dedicated
    step(2'b00, 1, 0, 1'b0);
    step(2'b00, 1, 0, 1'b0);
    chk("t2_shared_1", obs_ca[1], 3);
    chk("t2_ded0_0a", obs_ca[0], 1);
    step(2'b00, 1, 0, 1'b0);
    chk("t2_shared_2", obs_ca[1], 4);
    chk("t2_ded0_0b", obs_ca[0], 2);
    step(2'b00, 0, 0, 1'b0);
    chk("t2_ded0_1", obs_ca[0], 3);

    // Both VCs busy with credits recycled: link alternates 0,1,0,1
    step(2'b00, 0, 0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(2'b11, (m_out[0] > 0) ? 1 : 0, (m_out[1] > 0) ? 1 : 0, 1'b0);
      if (k >= 1) begin
        chk("t3_pop_valid", obs_pv, 1);
        chk("t3_pop_vc_alt", obs_vc, (k - 1) % 2);
      end
    end

    // Grant and return on VC0 in one cycle leaves ded[0] unchanged
    step(2'b00, 0, 0, 1'b1);
    step(2'b01, 0, 0, 1'b0);
    step(2'b01, 1, 0, 1'b0);
    chk("t4_grant", obs_ready, 1);
    chk("t4_ca0_before", obs_ca[0], 3);
    step(2'b00, 0, 0, 1'b0);
    chk("t4_ded0_holds", obs_ca[0], 3);
    chk("t4_model_ded0", m_ded[0], 1);

    // Over-return on VC1 at reset state: sticky error, ded saturates
    step(2'b00, 0, 0, 1'b1);
    step(2'b00, 0, 1, 1'b0);
    chk("t5_no_err_yet", obs_err, 0);
    step(2'b00, 0, 0, 1'b0);
    chk("t5_err_set", obs_err, 1);
    chk("t5_ca1_sat", obs_ca[1], 4);
    step(2'b00, 0, 0, 1'b0);
    chk("t5_err_sticky", obs_err, 1);

    // Far-end reset mid-traffic restores everything
    step(2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b11, 0, 0, 1'b0);
    step(2'b11, 0, 0, 1'b1);
    step(2'b00, 0, 0, 1'b0);
    chk("t6_pop_valid", obs_pv, 0);
    chk("t6_ca0", obs_ca[0], 4);
    chk("t6_ca1", obs_ca[1], 4);
    chk("t6_err", obs_err, 0);

    // Randomized traffic with legal holds, bounded returns and rare faults
    pend = '0;
    for (int n = 0; n < 600; n++) begin
      for (int v = 0; v < NV; v++) begin
        pv[v] = pend[v] ? 1'b1 : ($urandom_range(0, 99) < 60);
        mx    = (m_out[v] < PCMC) ? m_out[v] : PCMC;
        rc[v] = int'($urandom_range(0, mx));
        if ($urandom_range(0, 199) == 0) rc[v] = PCMC;
      end
      rir = ($urandom_range(0, 149) == 0);
      step(pv, rc[0], rc[1], rir);
      for (int v = 0; v < NV; v++) pend[v] = pv[v] && (last_win != v) && !rir;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
